// File: rtl/dmux8_sched_pkg.sv
// Shared types and constants for the dmux8 round-robin scheduler.
// Optional destination mask feature is enabled by defining DMUX8_SCHED_MASK_EN.
package dmux8_sched_pkg;

   localparam int unsigned NDST  = 8;
   localparam int unsigned SEL_W = 3;
   localparam int unsigned CNT_W = 16;

   typedef enum logic {
      StIdle,
      StSend
   } state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/dmux8_rr_next.sv
// Combinational finder for the first enabled destination after cur_i (cyclic).
// Returns cur_i itself when it is the sole enabled destination.
module dmux8_rr_next
   import dmux8_sched_pkg::*;
(
   input  logic [SEL_W-1:0] cur_i,
   input  logic [NDST-1:0]  mask_i,
   output logic [SEL_W-1:0] nxt_o,
   output logic             any_o
);

   logic             found;
   logic [SEL_W-1:0] idx;

   always_comb begin
      nxt_o = cur_i;
      any_o = |mask_i;
      found = 1'b0;
      idx   = cur_i;
      // Offset 8 wraps to cur_i so a sole enabled destination selects itself.
      for (int i = 1; i <= NDST; i++) begin
         idx = cur_i + SEL_W'(i);
         if (!found && mask_i[idx]) begin
            nxt_o = idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmux8_sched.sv
// Round-robin scheduler feeding a 1-to-8 demux: holds one word and hands it to the
// current destination. Define DMUX8_SCHED_MASK_EN to add the dst_mask_i enable port.
module dmux8_sched
   import dmux8_sched_pkg::*;
#(
   parameter int unsigned N   = 6,
   parameter int unsigned TMO = 15
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [N-1:0]     in_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [N-1:0]     out_data_o,
   output logic [SEL_W-1:0] out_sel_o,
   output logic [NDST-1:0]  out_valid_o,
   input  logic [NDST-1:0]  out_ready_i,
`ifdef DMUX8_SCHED_MASK_EN
   input  logic [NDST-1:0]  dst_mask_i,
`endif
   output logic [CNT_W-1:0] sent_cnt_o,
   output logic [7:0]       skip_cnt_o
);

   localparam int unsigned STALL_W = (TMO < 2) ? 1 : $clog2(TMO + 1);

   state_e             state_q, state_d;
   logic [N-1:0]       data_q, data_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0]   sent_q, sent_d;
   logic [7:0]         skip_q, skip_d;

   logic [NDST-1:0]    mask;
   logic [SEL_W-1:0]   nxt;
   logic               any;
   logic               fire;
   logic               accept;
   logic               tmo_hit;

`ifdef DMUX8_SCHED_MASK_EN
   assign mask = dst_mask_i;
`else
   assign mask = {NDST{1'b1}};
`endif

   dmux8_rr_next u_rr_next (
      .cur_i  (sel_q),
      .mask_i (mask),
      .nxt_o  (nxt),
      .any_o  (any)
   );

   assign out_valid_o = (state_q == StSend) ? (NDST'(1) << sel_q) : '0;
   assign fire        = (state_q == StSend) & out_ready_i[sel_q] & any;
   // Held low during reset even though the state already reads idle.
   assign in_ready_o  = rst_ni & any & ((state_q == StIdle) | fire);
   assign accept      = in_valid_i & in_ready_o;
   assign tmo_hit     = (TMO != 0) && (stall_q == STALL_W'(TMO - 1));

   assign out_data_o  = data_q;
   assign out_sel_o   = sel_q;
   assign sent_cnt_o  = sent_q;
   assign skip_cnt_o  = skip_q;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sel_d   = sel_q;
      stall_d = stall_q;
      sent_d  = sent_q;
      skip_d  = skip_q;
      if (fire) begin
         sent_d  = sent_q + 16'd1;
         sel_d   = nxt;
         stall_d = '0;
         if (accept) begin
            data_d = in_data_i;
         end else begin
            state_d = StIdle;
         end
      end else if (state_q == StSend) begin
         // With no destination enabled the held word and stall count freeze.
         if (any) begin
            if (!mask[sel_q] || tmo_hit) begin
               sel_d   = nxt;
               stall_d = '0;
               skip_d  = sat_inc8(skip_q);
            end else begin
               stall_d = stall_q + 1'b1;
            end
         end
      end else if (accept) begin
         data_d  = in_data_i;
         state_d = StSend;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         data_q  <= '0;
         sel_q   <= '0;
         stall_q <= '0;
         sent_q  <= '0;
         skip_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         stall_q <= stall_d;
         sent_q  <= sent_d;
         skip_q  <= skip_d;
      end
   end

endmodule

// File: tb/tb_dmux8_sched.sv
// Directed self-checking bench for dmux8_sched (N=6, TMO=15).
// Mask scenario is compiled only when DMUX8_SCHED_MASK_EN is defined.
module tb_dmux8_sched;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [5:0]  in_data_i = '0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [5:0]  out_data_o;
   logic [2:0]  out_sel_o;
   logic [7:0]  out_valid_o;
   logic [7:0]  out_ready_i = '0;
`ifdef DMUX8_SCHED_MASK_EN
   logic [7:0]  dst_mask_i = 8'hFF;
`endif
   logic [15:0] sent_cnt_o;
   logic [7:0]  skip_cnt_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   dmux8_sched #(.N(6), .TMO(15)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_data_i   (in_data_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .out_data_o  (out_data_o),
      .out_sel_o   (out_sel_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
`ifdef DMUX8_SCHED_MASK_EN
      .dst_mask_i  (dst_mask_i),
`endif
      .sent_cnt_o  (sent_cnt_o),
      .skip_cnt_o  (skip_cnt_o)
   );

   task automatic do_reset();
      in_valid_i  = 1'b0;
      out_ready_i = 8'hFF;
      rst_ni      = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      in_valid_i  = 1'b0;
      out_ready_i = 8'hFF;
      rst_ni      = 1'b0;
      repeat (2) @(negedge clk_i);
      checks++;
      if (in_ready_o !== 1'b0 || out_valid_o !== 8'h00 || out_sel_o !== 3'd0 ||
          out_data_o !== 6'h00 || sent_cnt_o !== 16'h0 || skip_cnt_o !== 8'h0) begin
         errors++;
         $display("FAIL reset_state: rdy=%b val=%h sel=%0d data=%h sent=%0d skip=%0d, want 0",
                  in_ready_o, out_valid_o, out_sel_o, out_data_o, sent_cnt_o, skip_cnt_o);
      end
      rst_ni = 1'b1;
      #1;
      checks++;
      if (in_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b want 1", in_ready_o);
      end
      @(negedge clk_i);
   endtask

   task automatic test_stream();
      in_data_i  = 6'd1;
      in_valid_i = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_i);
         #1;
         checks++;
         if (out_sel_o !== 3'(k - 1) || out_data_o !== 6'(k) ||
             out_valid_o !== (8'h01 << (k - 1))) begin
            errors++;
            $display("FAIL stream_word%0d: sel=%0d data=%h val=%h want sel=%0d data=%h",
                     k, out_sel_o, out_data_o, out_valid_o, k - 1, k);
         end
         if (k < 8) in_data_i = 6'(k + 1);
         else in_valid_i = 1'b0;
      end
      @(negedge clk_i);
      #1;
      checks++;
      if (sent_cnt_o !== 16'd8 || out_sel_o !== 3'd0 || out_valid_o !== 8'h00 ||
          in_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL stream_done: sent=%0d sel=%0d val=%h rdy=%b want 8,0,00,1",
                  sent_cnt_o, out_sel_o, out_valid_o, in_ready_o);
      end
   endtask

   task automatic test_timeout();
      out_ready_i = 8'hFB;
      in_valid_i  = 1'b1;
      in_data_i   = 6'h10;
      @(negedge clk_i);
      in_data_i = 6'h11;
      @(negedge clk_i);
      in_data_i = 6'h12;
      @(negedge clk_i);
      in_valid_i = 1'b0;
      for (int i = 0; i < 15; i++) begin
         #1;
         checks++;
         if (out_valid_o !== 8'h04 || out_data_o !== 6'h12 || skip_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL stall_hold%0d: val=%h data=%h skip=%0d want 04,12,0",
                     i, out_valid_o, out_data_o, skip_cnt_o);
         end
         @(negedge clk_i);
      end
      #1;
      checks++;
      if (out_sel_o !== 3'd3 || out_data_o !== 6'h12 || skip_cnt_o !== 8'd1 ||
          out_valid_o !== 8'h08) begin
         errors++;
         $display("FAIL timeout_skip: sel=%0d data=%h skip=%0d val=%h want 3,12,1,08",
                  out_sel_o, out_data_o, skip_cnt_o, out_valid_o);
      end
      @(negedge clk_i);
      #1;
      checks++;
      if (sent_cnt_o !== 16'd11 || out_sel_o !== 3'd4 || out_valid_o !== 8'h00) begin
         errors++;
         $display("FAIL skip_then_fire: sent=%0d sel=%0d val=%h want 11,4,00",
                  sent_cnt_o, out_sel_o, out_valid_o);
      end
      out_ready_i = 8'hFF;
   endtask

   task automatic test_toggle();
      logic [5:0] q[$];
      logic [5:0] nextd;
      logic [5:0] expd;
      int         exp_ptr;
      int         delivered;
      bit         fired;
      nextd     = 6'h20;
      exp_ptr   = 4;
      delivered = 0;
      checks++;
      if (out_sel_o !== 3'd4) begin
         errors++;
         $display("FAIL toggle_start_sel: got %0d want 4", out_sel_o);
      end
      for (int cyc = 0; cyc < 80; cyc++) begin
         @(negedge clk_i);
         if (cyc < 60) begin
            case (cyc % 3)
               0:       out_ready_i = 8'hFF;
               1:       out_ready_i = 8'h55;
               default: out_ready_i = 8'hAA;
            endcase
            in_valid_i = 1'b1;
            in_data_i  = nextd;
         end else begin
            out_ready_i = 8'hFF;
            in_valid_i  = 1'b0;
         end
         #1;
         fired = out_valid_o[out_sel_o] & out_ready_i[out_sel_o];
         if (fired) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL toggle_dup: delivered data=%h with nothing pending", out_data_o);
            end else begin
               expd = q.pop_front();
               if (out_data_o !== expd || out_sel_o !== 3'(exp_ptr)) begin
                  errors++;
                  $display("FAIL toggle_order: data=%h sel=%0d want data=%h sel=%0d",
                           out_data_o, out_sel_o, expd, exp_ptr);
               end
            end
            exp_ptr = (exp_ptr + 1) % 8;
            delivered++;
         end
         if (in_valid_i && in_ready_o) begin
            q.push_back(nextd);
            nextd = nextd + 6'd1;
         end
      end
      @(negedge clk_i);
      #1;
      checks++;
      if (q.size() != 0 || sent_cnt_o !== 16'(11 + delivered) || skip_cnt_o !== 8'd1) begin
         errors++;
         $display("FAIL toggle_drain: pending=%0d sent=%0d skip=%0d want 0,%0d,1",
                  q.size(), sent_cnt_o, skip_cnt_o, 11 + delivered);
      end
   endtask

   task automatic test_reset_mid();
      out_ready_i = 8'h00;
      in_valid_i  = 1'b1;
      in_data_i   = 6'h2A;
      @(negedge clk_i);
      in_valid_i = 1'b0;
      #1;
      checks++;
      if (out_valid_o === 8'h00 || out_data_o !== 6'h2A) begin
         errors++;
         $display("FAIL midrst_held: val=%h data=%h want nonzero,2A", out_valid_o, out_data_o);
      end
      #2;
      rst_ni = 1'b0;
      #1;
      checks++;
      if (out_valid_o !== 8'h00 || out_sel_o !== 3'd0 || sent_cnt_o !== 16'd0 ||
          skip_cnt_o !== 8'd0 || in_ready_o !== 1'b0 || out_data_o !== 6'h00) begin
         errors++;
         $display("FAIL midrst_async: val=%h sel=%0d sent=%0d skip=%0d rdy=%b data=%h",
                  out_valid_o, out_sel_o, sent_cnt_o, skip_cnt_o, in_ready_o, out_data_o);
      end
      @(negedge clk_i);
      out_ready_i = 8'hFF;
      rst_ni      = 1'b1;
      repeat (3) @(negedge clk_i);
      #1;
      checks++;
      if (out_valid_o !== 8'h00 || sent_cnt_o !== 16'd0) begin
         errors++;
         $display("FAIL midrst_discard: val=%h sent=%0d want 00,0", out_valid_o, sent_cnt_o);
      end
   endtask

`ifdef DMUX8_SCHED_MASK_EN
   task automatic test_mask();
      logic [2:0] exp_sel [4];
      exp_sel = '{3'd0, 3'd5, 3'd7, 3'd0};
      do_reset();
      dst_mask_i = 8'b1010_0001;
      in_valid_i = 1'b1;
      in_data_i  = 6'h01;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         #1;
         checks++;
         if (out_sel_o !== exp_sel[k] || out_data_o !== 6'(k + 1)) begin
            errors++;
            $display("FAIL mask_order%0d: sel=%0d data=%h want sel=%0d data=%h",
                     k, out_sel_o, out_data_o, exp_sel[k], k + 1);
         end
         in_data_i = 6'(k + 2);
      end
      dst_mask_i = 8'h00;
      #1;
      checks++;
      if (in_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL mask_zero_ready: got %b want 0", in_ready_o);
      end
      in_valid_i = 1'b0;
      dst_mask_i = 8'hFF;
      repeat (2) @(negedge clk_i);
   endtask
`endif

   task automatic test_wrap();
      int  n;
      bit  reached;
      do_reset();
      n           = 0;
      reached     = 1'b0;
      out_ready_i = 8'hFF;
      in_valid_i  = 1'b1;
      in_data_i   = 6'h15;
      for (int cyc = 0; cyc < 70000; cyc++) begin
         @(negedge clk_i);
         #1;
         if (out_valid_o[out_sel_o] & out_ready_i[out_sel_o]) n++;
         if (n == 65535) begin
            in_valid_i = 1'b0;
            reached    = 1'b1;
            break;
         end
      end
      checks++;
      if (!reached) begin
         errors++;
         $display("FAIL wrap_budget: only %0d deliveries seen, want 65535", n);
      end
      @(negedge clk_i);
      #1;
      checks++;
      if (sent_cnt_o !== 16'hFFFF || out_sel_o !== 3'd7) begin
         errors++;
         $display("FAIL wrap_pre: sent=%h sel=%0d want FFFF,7", sent_cnt_o, out_sel_o);
      end
      in_valid_i = 1'b1;
      in_data_i  = 6'h05;
      @(negedge clk_i);
      in_valid_i = 1'b0;
      @(negedge clk_i);
      #1;
      checks++;
      if (sent_cnt_o !== 16'h0000 || out_sel_o !== 3'd0) begin
         errors++;
         $display("FAIL wrap_post: sent=%h sel=%0d want 0000,0", sent_cnt_o, out_sel_o);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_timeout();
      test_toggle();
      test_reset_mid();
`ifdef DMUX8_SCHED_MASK_EN
      test_mask();
`endif
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
